mem_bus_responder: RTL
======================

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning data RAM depth in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter LED_W, default 16, meaning width of LED output register.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port memwrite  input  1  store strobe from the core memory stage.
REQ-006 SHALL have port addr  input  32  byte address (the core's aluoutM).
REQ-007 SHALL have port writedata  input  32  store data.
REQ-008 SHALL have port readdata  output  32  load data, combinational from addr in the same cycle.
REQ-009 SHALL have port led  output  LED_W  LED register contents.
REQ-010 SHALL have port timer_irq  output  1  match flag AND irq enable.
REQ-011 SHALL have port bus_err  output  1  registered one-cycle pulse for a misaligned or unmapped access.

Function
REQ-012 SHALL decode addr[31:16]==16'h0000 as RAM; word index = addr[log2(RAM_WORDS)+1:2]; higher addr bits within the region alias.
REQ-013 SHALL decode addr[31:8]==24'h100000 as MMIO, with offsets 0x00 LED (RW), 0x04 COUNT (RW), 0x08 CMP (RW), 0x0C STATUS (bit0 match flag, W1C), and 0x10 CTRL (bit0 irq enable, RW).
REQ-014 SHALL treat all other addresses, and MMIO offsets 0x14..0xFC, as unmapped.
REQ-015 SHALL treat addr[1:0]!=0 as misaligned regardless of region.
REQ-016 SHALL make RAM reads asynchronous: readdata = mem[index] in the same cycle, with no wait states.
REQ-017 SHALL write RAM on the rising edge while memwrite=1; a same-cycle read of the same word returns old data, and new data appears after the edge.
REQ-018 SHALL return, on an MMIO read, the zero-extended register value; unused bits read 0.
REQ-019 SHALL return readdata=0 and suppress any write for unmapped or misaligned accesses.
REQ-020 SHALL set bus_err=1 in the cycle after any unmapped or misaligned access, whether read or write; bus_err=0 otherwise.
REQ-021 SHALL increment COUNT by 1 every cycle, wrapping 0xFFFFFFFF->0x00000000.
REQ-022 SHALL, on a COUNT write, load COUNT with writedata on the edge instead of incrementing it.
REQ-023 SHALL set the match flag on the next edge when registered COUNT == CMP; the flag is sticky.
REQ-024 SHALL clear the flag on a STATUS write with writedata[0]=1; a writedata[0]=0 write has no effect.
REQ-025 SHALL let set win over clear when a match and a W1C occur in the same cycle.
REQ-026 SHALL load LED from writedata[LED_W-1:0] on a write.
REQ-027 SHALL make timer_irq combinational from registered flag & CTRL[0].

Reset
REQ-028 SHALL, while rst=1, asynchronously force LED=0, COUNT=0, CMP=0xFFFFFFFF, flag=0, CTRL=0, bus_err=0.
REQ-029 SHALL hold COUNT at 0 during reset.
REQ-030 SHALL ignore writes during reset.
REQ-031 SHALL not reset RAM contents, which are undefined.
REQ-032 SHALL restart COUNT at 0 on the first edge after deassertion, so the first increment yields 1.
REQ-033 SHALL, on reset assertion mid-operation, abandon any in-flight write with no partial update.

Verification
REQ-034 SHALL verify RAM store then load: write 0xDEADBEEF to 0x00000040, then read 0x00000040 -> readdata=0xDEADBEEF; read 0x00000044 must not be affected.
REQ-035 SHALL verify same-cycle read-during-write: mem[0x10]=0x1; write 0x2 while reading 0x10 -> 0x1 that cycle, 0x2 the next.
REQ-036 SHALL verify the timer: CMP=0x20, CTRL=1, COUNT=0x1C -> flag and timer_irq rise 5 edges later; W1C STATUS -> timer_irq falls next cycle.
REQ-037 SHALL verify set-vs-clear: a W1C in the same cycle as a match -> flag stays 1.
REQ-038 SHALL verify errors: write 0x5 to 0x00000042 or to 0x20000000 -> RAM/regs unchanged, readdata=0, bus_err pulses exactly one cycle.
REQ-039 SHALL verify counter wrap and reset: write COUNT=0xFFFFFFFE -> reads 0xFFFFFFFF then 0x0; assert rst mid-run -> all registers at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: word RAM plus LED/timer MMIO slave for the core memory stage
module mem_bus_responder #(
  parameter int RAM_WORDS = 256,
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memwrite,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led,
  output logic             timer_irq,
  output logic             bus_err
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] mem [RAM_WORDS];
  logic [31:0] count, cmp, mmioData;
  logic flag, irqEn, ramSel, mmioSel, ramWe, regWe;
  logic [AW-1:0] wordIdx;
  logic [2:0] regSel;
  // Address decode and combinational read mux; misaligned or unmapped reads return zero
  always_comb begin
    ramSel = addr[1:0] == 2'b00 && addr[31:16] == 16'h0000;
    mmioSel = addr[1:0] == 2'b00 && addr[31:8] == 24'h100000 && addr[7:0] <= 8'h10;
    wordIdx = addr[AW+1:2];
    regSel = addr[4:2];
    ramWe = memwrite && ramSel && !rst;
    regWe = memwrite && mmioSel;
    mmioData = regSel == 3'd0 ? 32'(led) :
               regSel == 3'd1 ? count :
               regSel == 3'd2 ? cmp :
               regSel == 3'd3 ? {31'b0, flag} : {31'b0, irqEn};
    readdata = ramSel ? mem[wordIdx] : mmioSel ? mmioData : 32'h0;
    timer_irq = flag && irqEn;
  end
  // RAM store; gated by rst so a write caught by reset assertion never lands
  always_ff @(posedge clk) begin
    if (ramWe) mem[wordIdx] <= writedata;
  end
  // MMIO registers, free-running counter, sticky match flag (set beats clear), error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
      count <= 32'h0;
      cmp <= 32'hFFFF_FFFF;
      flag <= 1'b0;
      irqEn <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= !(ramSel || mmioSel);
      count <= regWe && regSel == 3'd1 ? writedata : count + 32'd1;
      if (regWe && regSel == 3'd0) led <= writedata[LED_W-1:0];
      if (regWe && regSel == 3'd2) cmp <= writedata;
      flag <= count == cmp || (flag && !(regWe && regSel == 3'd3 && writedata[0]));
      if (regWe && regSel == 3'd4) irqEn <= writedata[0];
    end
  end
endmodule
